dds_sequencer: RTL and testbench
================================

# dds_sequencer

Phase-accumulator controller that sequences the shared 64-entry quarter-wave sine ROM and its sign/magnitude datapath. Accepts frequency/phase configuration through a valid/ready handshake and applies it only at a waveform wrap, so output stays glitch-free. Supports start/stop with stop deferred to the next wrap, so the wave always ends at phase zero. Drives ROM address, mirror/peak selects and sign for the downstream magnitude/sign logic that produces sine, full-wave and half-wave outputs.

## Interface
- ACC_W, 16: phase accumulator width. Top 8 bits are the phase: [ACC_W-1:ACC_W-2] quadrant, [ACC_W-3:ACC_W-8] ROM index.
- clk  in  1  sole clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- start  in  1  level/pulse; begin generation from IDLE, or cancel a pending stop
- stop  in  1  request stop at next wrap
- cfg_valid  in  1  config offer
- cfg_ready  out  1  config slot free
- cfg_fword  in  ACC_W  frequency tuning word
- cfg_phase  in  ACC_W  phase offset
- rom_addr  out  6  ROM index, mirrored in quadrants 1 and 3
- peak_sel  out  1  force magnitude 255 instead of ROM data
- sign  out  1  1 in quadrants 2 and 3
- quadrant  out  2  current quadrant
- active  out  1  samples valid (RUN or STOPPING)
- wrap  out  1  one-cycle pulse when the accumulator has just wrapped

## Operation
- Registers: acc, fword, phase, pend_fword, pend_phase, pend_flag, state, wrap.
- States: IDLE, RUN, STOPPING.
- IDLE: acc holds phase. start=1 -> RUN, acc <= phase. start and stop both high -> stay IDLE.
- RUN: acc <= acc + fword mod 2^ACC_W every cycle; carry out = wrap event. stop=1 -> STOPPING (stop wins over start).
- STOPPING: keeps accumulating; start=1 (stop=0) -> RUN. On wrap event -> IDLE, acc <= phase.
- fword == 0 with stop: go straight to IDLE next cycle (no wrap will occur).
- Config in IDLE: handshake completes, fword/phase load next cycle, acc <= cfg_phase, cfg_ready stays 1.
- Config in RUN/STOPPING: captured into pend_* on handshake, cfg_ready drops to 0. On next wrap event: fword <= pend_fword, phase <= pend_phase, acc <= sum + (pend_phase - phase) mod 2^ACC_W, pend_flag clears, cfg_ready returns to 1 the following cycle. If current fword == 0, pending config applies on the next cycle without a wrap.
- Wrap event coinciding with STOPPING->IDLE applies pending config first; acc then loads the new phase.
- Output decode from acc top byte (idx = 6-bit index):
- q0: rom_addr=idx, sign=0, peak_sel=0.
- q1: rom_addr=(~idx)+1 (6-bit), sign=0, peak_sel=(idx==0).
- q2: rom_addr=idx, sign=1, peak_sel=0.
- q3: rom_addr=(~idx)+1, sign=1, peak_sel=(idx==0).
- fword >= 2^(ACC_W-1) is legal (aliased); no special handling.

## Timing
- Reset values: state IDLE, acc 0, fword 0, phase 0, pend_flag 0, cfg_ready 1, active 0, wrap 0, rom_addr 0, sign 0, peak_sel 0, quadrant 0.
- Outputs decoded combinationally from registered acc/state: zero-latency relative to acc.
- start sampled at edge N -> active=1 and first sample (phase offset) during cycle N+1.
- wrap high for exactly the one cycle in which acc holds the post-wrap value.
- cfg handshake completes on an edge with cfg_valid & cfg_ready; at most one pending config.
- Reset mid-operation: all registers return to reset values immediately; pending config discarded.

## Structure
- dds_pkg: ACC_W default, ROM_AW=6, quadrant constants Q0..Q3, state enum (IDLE/RUN/STOPPING), PEAK_MAG=255.
- One sub-module: dds_phase_acc (ACC_W adder with carry out and load mux for acc).
- FSM, config holding registers and quadrant decode live in dds_sequencer.

## Test plan
- Reset, fword=0x0100, phase=0, start -> acc top byte 0,1,2,...; cycle 64 after start: quadrant=1, rom_addr=0, peak_sel=1; next cycle rom_addr=63; wrap every 256 cycles.
- phase=0x8000, start -> first sample quadrant=2, sign=1, rom_addr=0; active=1 the cycle after start.
- Running fword=0x0100; offer fword=0x0200 at cycle 10 -> cfg_ready=0 until wrap at cycle 256; step becomes 2 only after the wrap; cfg_ready=1 next cycle.
- stop at cycle 100 -> active stays 1 until wrap at cycle 256, then IDLE, rom_addr=0, sign=0; start in cycle 150 instead -> continues in RUN with no gap.
- fword=0 running, stop -> IDLE next cycle; config with fword=0x0100 while running at fword=0 -> applied next cycle.
- Assert rst mid-RUN with pending config -> all outputs to reset values immediately; cfg_ready=1; pending config not applied after release.

Source files
------------

// File: rtl/dds_pkg.sv
// Shared constants and types for the DDS phase sequencer.
package dds_pkg;

  localparam int ACC_W_DEF = 16;
  localparam int ROM_AW    = 6;
  localparam logic [7:0] PEAK_MAG = 8'd255;

  // Quadrant codes taken from the top two accumulator bits.
  localparam logic [1:0] Q0 = 2'd0;
  localparam logic [1:0] Q1 = 2'd1;
  localparam logic [1:0] Q2 = 2'd2;
  localparam logic [1:0] Q3 = 2'd3;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    STOPPING = 2'd2
  } state_t;

endpackage

// File: rtl/dds_sequencer_if.sv
// Configuration channel for the DDS sequencer.
// Handshake: a transfer happens on a rising clk edge where cfg_valid and
// cfg_ready are both 1; the master holds cfg_valid/cfg_fword/cfg_phase stable
// until that edge, and cfg_ready never depends combinationally on cfg_valid.
interface dds_sequencer_if #(parameter int ACC_W = 16) ();
  logic             cfg_valid;
  logic             cfg_ready;
  logic [ACC_W-1:0] cfg_fword;
  logic [ACC_W-1:0] cfg_phase;

  modport master (output cfg_valid, output cfg_fword, output cfg_phase, input cfg_ready);
  modport slave  (input cfg_valid, input cfg_fword, input cfg_phase, output cfg_ready);
endinterface

// File: rtl/dds_phase_acc.sv
// Phase accumulator register: adder with carry out plus a load mux.
// carry reflects acc + fword for the current cycle and marks a wrap event.
module dds_phase_acc #(parameter int ACC_W = 16) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [ACC_W-1:0] load_val,
  input  logic             step,
  input  logic [ACC_W-1:0] fword,
  input  logic [ACC_W-1:0] adj,
  output logic [ACC_W-1:0] acc,
  output logic             carry
);

  logic [ACC_W:0] sum_ext;

  // Unsigned add with the carry kept as the wrap indicator.
  always_comb begin
    sum_ext = {1'b0, acc} + {1'b0, fword};
    carry   = sum_ext[ACC_W];
  end

  // Load wins over step; adj carries the phase re-alignment on config apply.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (load) begin
      acc <= load_val;
    end else if (step) begin
      acc <= sum_ext[ACC_W-1:0] + adj;
    end
  end

endmodule

// File: rtl/dds_sequencer.sv
// DDS sequencer: start/stop FSM, wrap-synchronous config update and
// quadrant decode of the phase accumulator into ROM address/sign/peak.
module dds_sequencer
  import dds_pkg::*;
#(parameter int ACC_W = ACC_W_DEF)
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  dds_sequencer_if.slave    cfg,
  output logic [ROM_AW-1:0] rom_addr,
  output logic              peak_sel,
  output logic              sign,
  output logic [1:0]        quadrant,
  output logic              active,
  output logic              wrap,
  output state_t            state_dbg
);

  state_t           state;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] fword;
  logic [ACC_W-1:0] phase;
  logic [ACC_W-1:0] pend_fword;
  logic [ACC_W-1:0] pend_phase;
  logic             pend_flag;
  logic             carry;

  logic             running;
  logic             hs;
  logic             zero_f;
  logic             resume;
  logic             apply;
  logic             go_idle;
  logic             acc_load;
  logic             acc_step;
  logic [ACC_W-1:0] acc_load_val;
  logic [ACC_W-1:0] acc_adj;
  logic [ROM_AW-1:0] idx;
  logic             unused_acc_low;

  // Control decisions for the coming edge. A pending config is applied at a
  // wrap, immediately when fword is zero (no wrap will ever come), or in IDLE.
  always_comb begin
    running      = (state != IDLE);
    hs           = cfg.cfg_valid & ~pend_flag;
    zero_f       = (fword == '0);
    resume       = start & ~stop;
    apply        = pend_flag & (~running | carry | zero_f);
    go_idle      = ((state == RUN) & stop & zero_f) |
                   ((state == STOPPING) & ~resume & (carry | zero_f));
    acc_load     = ~running | go_idle;
    acc_step     = running & ~go_idle;
    acc_load_val = (~running & hs) ? cfg.cfg_phase : (apply ? pend_phase : phase);
    acc_adj      = apply ? (pend_phase - phase) : '0;
  end

  dds_phase_acc #(.ACC_W(ACC_W)) u_acc (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (acc_load),
    .load_val (acc_load_val),
    .step     (acc_step),
    .fword    (fword),
    .adj      (acc_adj),
    .acc      (acc),
    .carry    (carry)
  );

  // FSM plus config holding registers and the registered wrap pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      fword      <= '0;
      phase      <= '0;
      pend_fword <= '0;
      pend_phase <= '0;
      pend_flag  <= 1'b0;
      wrap       <= 1'b0;
    end else begin
      wrap <= running & carry;
      if (apply) begin
        fword     <= pend_fword;
        phase     <= pend_phase;
        pend_flag <= 1'b0;
      end else if (~running & hs) begin
        fword <= cfg.cfg_fword;
        phase <= cfg.cfg_phase;
      end
      if (running & hs) begin
        pend_fword <= cfg.cfg_fword;
        pend_phase <= cfg.cfg_phase;
        pend_flag  <= 1'b1;
      end
      case (state)
        IDLE:     if (resume) state <= RUN;
        RUN:      if (stop) state <= zero_f ? IDLE : STOPPING;
        STOPPING: begin
          if (resume) state <= RUN;
          else if (carry | zero_f) state <= IDLE;
        end
        default:  state <= IDLE;
      endcase
    end
  end

  // Quadrant decode: odd quadrants run the ROM backwards, with index 0
  // there meaning the peak (address 64 does not exist in the ROM).
  always_comb begin
    quadrant = acc[ACC_W-1 -: 2];
    idx      = acc[ACC_W-3 -: ROM_AW];
    sign     = (quadrant == Q2) | (quadrant == Q3);
    if ((quadrant == Q1) | (quadrant == Q3)) begin
      rom_addr = ~idx + 6'd1;
      peak_sel = (idx == '0);
    end else begin
      rom_addr = idx;
      peak_sel = 1'b0;
    end
  end

  assign active         = running;
  assign cfg.cfg_ready  = ~pend_flag;
  assign state_dbg      = state;
  assign unused_acc_low = ^acc[ACC_W-9:0];

endmodule

// File: tb/tb_dds_sequencer.sv
// Testbench for dds_sequencer: behavioural phase model feeding an expected
// queue, a monitor comparing every cycle, plus directed spot checks.
module tb_dds_sequencer;
  import dds_pkg::*;

  localparam int W = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              stop = 1'b0;
  logic [ROM_AW-1:0] rom_addr;
  logic              peak_sel;
  logic              sign;
  logic [1:0]        quadrant;
  logic              active;
  logic              wrap;
  state_t            state_dbg;

  dds_sequencer_if #(.ACC_W(W)) cfg_if ();

  dds_sequencer #(.ACC_W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .stop      (stop),
    .cfg       (cfg_if),
    .rom_addr  (rom_addr),
    .peak_sel  (peak_sel),
    .sign      (sign),
    .quadrant  (quadrant),
    .active    (active),
    .wrap      (wrap),
    .state_dbg (state_dbg)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  // Vector layout: {active, wrap, cfg_ready, sign, peak_sel, quadrant[1:0], rom_addr[5:0]}
  logic [12:0] exp_q[$];
  int checks = 0;
  int failures = 0;

  // ---------------- reference model ----------------
  bit          m_run, m_stopping, m_pend, m_wrap;
  int unsigned m_acc, m_fword, m_phase, m_pfw, m_pph;

  function automatic void model_reset();
    m_run = 0; m_stopping = 0; m_pend = 0; m_wrap = 0;
    m_acc = 0; m_fword = 0; m_phase = 0; m_pfw = 0; m_pph = 0;
  endfunction

  // Advance the model by one clock edge given the inputs seen at that edge.
  function automatic void model_step(bit st, bit sp, bit cv, int unsigned fw, int unsigned ph);
    bit          hs;
    bit          go_on;
    bit          wrapped;
    bit          no_step;
    bit          idle_now;
    int unsigned total;
    int unsigned nxt;
    hs    = cv && !m_pend;
    go_on = st && !sp;
    if (!m_run) begin
      m_wrap = 0;
      if (hs) begin
        m_fword = fw; m_phase = ph;
      end else if (m_pend) begin
        m_fword = m_pfw; m_phase = m_pph; m_pend = 0;
      end
      m_acc = m_phase;
      if (go_on) begin
        m_run = 1; m_stopping = 0;
      end
    end else begin
      total   = m_acc + m_fword;
      wrapped = (total >= 65536);
      no_step = (m_fword == 0);
      nxt     = total % 65536;
      if (m_stopping) idle_now = !go_on && (wrapped || no_step);
      else            idle_now = sp && no_step;
      if (m_pend && (wrapped || no_step)) begin
        nxt     = (nxt + 65536 + m_pph - m_phase) % 65536;
        m_fword = m_pfw; m_phase = m_pph; m_pend = 0;
      end else if (hs) begin
        m_pfw = fw; m_pph = ph; m_pend = 1;
      end
      if (idle_now) begin
        m_run = 0; m_stopping = 0; m_acc = m_phase;
      end else begin
        m_acc = nxt;
        if (m_stopping && go_on)   m_stopping = 0;
        else if (!m_stopping && sp) m_stopping = 1;
      end
      m_wrap = wrapped;
    end
  endfunction

  // Sine-table addressing from the phase: odd quadrants read the table backwards.
  function automatic logic [12:0] model_out();
    int unsigned top, q, idx, rom;
    bit          pk, sg;
    top = m_acc / 256;
    q   = top / 64;
    idx = top % 64;
    rom = (q % 2 == 1) ? (64 - idx) % 64 : idx;
    pk  = (q % 2 == 1) && (idx == 0);
    sg  = (q >= 2);
    return {m_run, m_wrap, !m_pend, sg, pk, 2'(q), 6'(rom)};
  endfunction

  function automatic logic [12:0] dut_vec();
    return {active, wrap, cfg_if.cfg_ready, sign, peak_sel, quadrant, rom_addr};
  endfunction

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- driver ----------------
  task automatic cycle(bit st, bit sp, bit cv, int unsigned fw, int unsigned ph);
    @(negedge clk);
    start            = st;
    stop             = sp;
    cfg_if.cfg_valid = cv;
    cfg_if.cfg_fword = fw[W-1:0];
    cfg_if.cfg_phase = ph[W-1:0];
    model_step(st, sp, cv, fw, ph);
    exp_q.push_back(model_out());
  endtask

  task automatic idle_cycles(int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0);
  endtask

  // Let the edge after the last driven cycle happen, then sample.
  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  // ---------------- monitor ----------------
  always @(posedge clk) begin
    #1;
    if (rst_n && exp_q.size() > 0) begin
      logic [12:0] e;
      e = exp_q.pop_front();
      check("cycle_outputs", dut_vec(), e);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int r;
    int unsigned fw;
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_fword = '0;
    cfg_if.cfg_phase = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset_outputs", dut_vec(), 13'h400);
    check("reset_state", state_dbg, IDLE);
    rst_n = 1'b1;

    // Step 0x0100 from phase 0: quadrant boundary at 64 samples.
    cycle(0, 0, 1, 'h0100, 0);
    cycle(1, 0, 0, 0, 0);
    idle_cycles(64);
    settle();
    check("q1_peak", {quadrant, rom_addr, peak_sel}, {2'd1, 6'd0, 1'b1});
    cycle(0, 0, 0, 0, 0);
    settle();
    check("q1_mirror_addr", rom_addr, 6'd63);

    // Config while running stays pending until the wrap.
    cycle(0, 0, 1, 'h0200, 0);
    settle();
    check("pending_blocks_ready", cfg_if.cfg_ready, 1'b0);
    idle_cycles(250);

    // Deferred stop ends at phase zero.
    cycle(0, 1, 0, 0, 0);
    idle_cycles(150);
    settle();
    check("stopped_idle", {active, rom_addr, sign}, 8'h00);

    // Start during STOPPING cancels the stop.
    cycle(1, 0, 0, 0, 0);
    idle_cycles(20);
    cycle(0, 1, 0, 0, 0);
    idle_cycles(30);
    cycle(1, 0, 0, 0, 0);
    idle_cycles(200);
    settle();
    check("cancel_keeps_running", active, 1'b1);
    cycle(0, 1, 0, 0, 0);
    idle_cycles(150);

    // Half-cycle phase offset: first sample is the negative zero crossing.
    cycle(0, 0, 1, 'h0100, 'h8000);
    cycle(1, 0, 0, 0, 0);
    settle();
    check("offset_first_sample", {active, quadrant, sign, rom_addr}, {1'b1, 2'd2, 1'b1, 6'd0});
    idle_cycles(10);
    cycle(0, 1, 0, 0, 0);
    idle_cycles(300);

    // Zero tuning word: stop is immediate, config applies without a wrap.
    cycle(0, 0, 1, 0, 'h1234);
    cycle(1, 0, 0, 0, 0);
    idle_cycles(5);
    cycle(0, 1, 0, 0, 0);
    settle();
    check("zero_fword_stop", active, 1'b0);
    cycle(1, 0, 0, 0, 0);
    idle_cycles(3);
    cycle(0, 0, 1, 'h0100, 0);
    cycle(0, 0, 0, 0, 0);
    settle();
    check("zero_fword_apply_ready", cfg_if.cfg_ready, 1'b1);
    idle_cycles(5);
    cycle(0, 1, 0, 0, 0);
    idle_cycles(300);

    // Randomised start/stop/config traffic.
    for (int i = 0; i < 3000; i++) begin
      bit st, sp, cv;
      r  = $urandom_range(0, 99);
      st = (r < 3);
      sp = (r >= 3 && r < 6);
      cv = !m_pend && ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 31) == 0)      fw = 0;
      else if ($urandom_range(0, 3) == 0) fw = $urandom_range(0, 65535);
      else                                 fw = $urandom_range('h400, 'h2000);
      cycle(st, sp, cv, fw, $urandom_range(0, 65535));
    end

    // Reset in RUN with a pending config.
    cycle(0, 1, 0, 0, 0);
    idle_cycles(300);
    cycle(0, 0, 1, 'h0100, 0);
    cycle(1, 0, 0, 0, 0);
    idle_cycles(20);
    cycle(0, 0, 1, 'h0300, 'h4000);
    cycle(0, 0, 0, 0, 0);
    settle();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrun_reset_outputs", dut_vec(), 13'h400);
    check("midrun_reset_state", state_dbg, IDLE);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    cycle(1, 0, 0, 0, 0);
    idle_cycles(300);
    settle();
    check("pending_discarded", {active, quadrant, rom_addr}, {1'b1, 2'd0, 6'd0});

    // Drain the expected queue with a bounded wait.
    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
    #3;
    check("queue_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
